alu_sequencer: RTL and testbench

Parametrised single-clock successor to the three-phase ALU in the CPU datapath. It accepts one decoded instruction per start handshake and steps an internal phase counter in place of the external clock_4/clock_6/clock_8 phases. Each phase emits one result (stack pointer, address, data or next eip) on alu_result_bus with a valid strobe. It adds configurable width, configurable stack step and direction, sign-extended displacements, a proper zero flag from sub/cmp, and illegal-opcode reporting.

---
 rtl/alu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Single-clock ALU sequencer: accepts one decoded instruction per start and
// emits one registered result per internal step (stack pointer, address, data, eip).
module alu_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned STACK_STEP = 4,
  parameter int unsigned STACK_DOWN = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ope,
  input  logic [3:0]       num_of_ope,
  input  logic [WIDTH-1:0] registor_in,
  output logic [1:0]       step,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic             zero,
  output logic             done,
  output logic             illegal
);

  localparam int unsigned OPE_W  = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned STEP_W = 2;
  localparam int unsigned IMM_W  = 24;
  localparam bit          DOWN   = (STACK_DOWN != 0);
  localparam logic [WIDTH-1:0] STEP_BYTES = WIDTH'(STACK_STEP);
  localparam logic [WIDTH-1:0] P_DELTA    = DOWN ? (~STEP_BYTES + WIDTH'(1)) : STEP_BYTES;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d, last_q, last_d, n_steps;
  logic [OPE_W-1:0]    ope_q, ope_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [WIDTH-1:0]    result_d, step_res;
  logic                valid_d, done_d, illegal_d, zero_d, zero_upd;

  logic [7:0]          opc, modrm, byte2, byte3;
  logic [IMM_W-1:0]    imm24;
  logic [WIDTH-1:0]    s8_modrm, s8_b2, s8_b3, imm_zx, imm_sx, len_w;

  // Step count per opcode; 0 marks an undecodable instruction.
  function automatic logic [STEP_W-1:0] decode_steps(input logic [7:0] op_b, input logic [7:0] mr);
    logic [STEP_W-1:0] n;
    n = '0;
    case (op_b)
      8'h55, 8'h53, 8'h6a, 8'h5d, 8'hc3, 8'h8b: n = 2'd2;
      8'he8, 8'hc9:                             n = 2'd3;
      8'h89, 8'hb8, 8'h75, 8'heb:               n = 2'd1;
      8'h83: begin
        case (mr)
          8'he8, 8'hc4, 8'hec: n = 2'd1;
          8'h7d:               n = 2'd2;
          default:             n = 2'd0;
        endcase
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign opc      = ope_q[31:24];
  assign modrm    = ope_q[23:16];
  assign byte2    = ope_q[15:8];
  assign byte3    = ope_q[7:0];
  assign imm24    = {byte3, byte2, modrm};
  assign s8_modrm = WIDTH'($signed(modrm));
  assign s8_b2    = WIDTH'($signed(byte2));
  assign s8_b3    = WIDTH'($signed(byte3));
  assign imm_zx   = WIDTH'(imm24);
  assign imm_sx   = WIDTH'($signed(imm24));
  assign len_w    = WIDTH'(len_q);

  assign step = step_q;
  assign busy = (state_q == EXEC);

  // Result of the current step from the latched instruction and registor_in.
  always_comb begin
    step_res = registor_in;
    zero_upd = 1'b0;
    case (opc)
      8'h55, 8'h53: step_res = (step_q == 2'd0) ? registor_in + P_DELTA : registor_in;
      8'h6a:        step_res = (step_q == 2'd0) ? registor_in + P_DELTA : s8_modrm;
      8'h5d, 8'hc3: step_res = (step_q == 2'd0) ? registor_in : registor_in - P_DELTA;
      8'he8: begin
        case (step_q)
          2'd0:    step_res = registor_in + P_DELTA;
          2'd1:    step_res = registor_in + len_w;
          default: step_res = registor_in + len_w + imm_sx;
        endcase
      end
      8'hc9:        step_res = (step_q == 2'd2) ? registor_in - P_DELTA : registor_in;
      8'h89:        step_res = registor_in;
      8'hb8:        step_res = imm_zx;
      8'h8b:        step_res = (step_q == 2'd0) ? registor_in + s8_b2 : registor_in;
      8'h83: begin
        case (modrm)
          8'he8: begin
            step_res = registor_in - s8_b2;
            zero_upd = 1'b1;
          end
          8'hc4:   step_res = DOWN ? registor_in + s8_b2 : registor_in - s8_b2;
          8'hec:   step_res = DOWN ? registor_in - s8_b2 : registor_in + s8_b2;
          8'h7d: begin
            step_res = (step_q == 2'd0) ? registor_in + s8_b2 : registor_in - s8_b3;
            zero_upd = (step_q != 2'd0);
          end
          default: step_res = registor_in;
        endcase
      end
      8'h75:        step_res = zero ? registor_in + len_w : registor_in + len_w + s8_modrm;
      8'heb:        step_res = registor_in + len_w + s8_modrm;
      default:      step_res = registor_in;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    ope_d     = ope_q;
    len_d     = len_q;
    result_d  = alu_result_bus;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    zero_d    = zero;
    n_steps   = decode_steps(ope[31:24], ope[23:16]);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_steps == '0) begin
            illegal_d = 1'b1;
          end else begin
            ope_d   = ope;
            len_d   = num_of_ope;
            last_d  = n_steps - 2'd1;
            step_d  = '0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d = step_res;
        valid_d  = 1'b1;
        if (zero_upd) zero_d = (step_res == '0);
        if (step_q == last_q) begin
          done_d  = 1'b1;
          step_d  = '0;
          state_d = IDLE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      step_q         <= '0;
      last_q         <= '0;
      ope_q          <= '0;
      len_q          <= '0;
      alu_result_bus <= '0;
      result_valid   <= 1'b0;
      done           <= 1'b0;
      illegal        <= 1'b0;
      zero           <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      last_q         <= last_d;
      ope_q          <= ope_d;
      len_q          <= len_d;
      alu_result_bus <= result_d;
      result_valid   <= valid_d;
      done           <= done_d;
      illegal        <= illegal_d;
      zero           <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (upward and downward stack) driven in
// lockstep, checked against an arithmetic reference model and a directed table.
module tb_alu_sequencer;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       ope = '0;
  logic [3:0]        num_of_ope = '0;
  logic [31:0]       registor_in = '0;
  logic [1:0]        stp [2];
  logic              bsy [2];
  logic              vld [2];
  logic [31:0]       bus [2];
  logic              zro [2];
  logic              dne [2];
  logic              ill [2];

  int checks = 0;
  int failures = 0;
  bit zf_m = 1'b0;
  logic [31:0] last_res [2];

  always #5 clock = ~clock;

  alu_sequencer #(.WIDTH(32), .STACK_STEP(4), .STACK_DOWN(0)) dut_up (
    .clock(clock), .reset(reset), .start(start), .ope(ope), .num_of_ope(num_of_ope),
    .registor_in(registor_in), .step(stp[0]), .busy(bsy[0]), .result_valid(vld[0]),
    .alu_result_bus(bus[0]), .zero(zro[0]), .done(dne[0]), .illegal(ill[0]));

  alu_sequencer #(.WIDTH(32), .STACK_STEP(4), .STACK_DOWN(1)) dut_dn (
    .clock(clock), .reset(reset), .start(start), .ope(ope), .num_of_ope(num_of_ope),
    .registor_in(registor_in), .step(stp[1]), .busy(bsy[1]), .result_valid(vld[1]),
    .alu_result_bus(bus[1]), .zero(zro[1]), .done(dne[1]), .illegal(ill[1]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic longint s8(input logic [7:0] x);
    return x[7] ? longint'(x) - 256 : longint'(x);
  endfunction

  function automatic logic [2:0][31:0] r3(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return {c, b, a};
  endfunction

  // Reference: the per-opcode results written as plain signed arithmetic.
  function automatic void model(input logic [31:0] op, input logic [3:0] len,
                                input logic [2:0][31:0] regs, input bit sd, input bit zf_in,
                                output int n, output logic [2:0][31:0] res, output bit zf_out);
    longint r [3];
    longint p, l, rel, imm;
    logic [7:0] opc, m, b2, b3;
    opc = op[31:24]; m = op[23:16]; b2 = op[15:8]; b3 = op[7:0];
    p = sd ? -4 : 4;
    l = longint'(len);
    imm = longint'({b3, b2, m});
    rel = (imm >= 64'h80_0000) ? imm - 64'h100_0000 : imm;
    r[0] = 0; r[1] = 0; r[2] = 0;
    n = 0;
    zf_out = zf_in;
    case (opc)
      8'h55, 8'h53: begin n = 2; r[0] = regs[0] + p; r[1] = regs[1]; end
      8'h6a:        begin n = 2; r[0] = regs[0] + p; r[1] = s8(m); end
      8'h5d, 8'hc3: begin n = 2; r[0] = regs[0]; r[1] = regs[1] - p; end
      8'he8: begin n = 3; r[0] = regs[0] + p; r[1] = regs[1] + l; r[2] = regs[2] + l + rel; end
      8'hc9:        begin n = 3; r[0] = regs[0]; r[1] = regs[1]; r[2] = regs[2] - p; end
      8'h89:        begin n = 1; r[0] = regs[0]; end
      8'hb8:        begin n = 1; r[0] = imm; end
      8'h8b:        begin n = 2; r[0] = regs[0] + s8(b2); r[1] = regs[1]; end
      8'h83: begin
        if (m == 8'he8) begin
          n = 1; r[0] = regs[0] - s8(b2); zf_out = (32'(r[0]) == 0);
        end else if (m == 8'hc4) begin
          n = 1; r[0] = regs[0] - s8(b2) * (sd ? -1 : 1);
        end else if (m == 8'hec) begin
          n = 1; r[0] = regs[0] + s8(b2) * (sd ? -1 : 1);
        end else if (m == 8'h7d) begin
          n = 2; r[0] = regs[0] + s8(b2); r[1] = regs[1] - s8(b3);
          zf_out = (32'(r[1]) == 0);
        end
      end
      8'h75: begin n = 1; r[0] = regs[0] + l + (zf_in ? 0 : s8(m)); end
      8'heb: begin n = 1; r[0] = regs[0] + l + s8(m); end
      default: n = 0;
    endcase
    for (int k = 0; k < 3; k++) res[k] = 32'(r[k]);
  endfunction

  // Issue one instruction at a falling edge; returns at the falling edge of its done cycle.
  task automatic run(input logic [31:0] op, input logic [3:0] len, input logic [2:0][31:0] regs,
                     input bit hold, output logic [2:0][31:0] g0, output logic [2:0][31:0] g1);
    int n, n1;
    logic [2:0][31:0] e [2];
    bit z0, z1;
    model(op, len, regs, 1'b0, zf_m, n, e[0], z0);
    model(op, len, regs, 1'b1, zf_m, n1, e[1], z1);
    zf_m = z0;
    g0 = '0; g1 = '0;
    start = 1'b1; ope = op; num_of_ope = len; registor_in = regs[0];
    @(negedge clock);
    if (n == 0) begin
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("illegal_pulse[%0d] op=%h", d, op), 64'(ill[d]), 64'd1);
        chk($sformatf("illegal_busy[%0d]", d), 64'(bsy[d]), 64'd0);
        chk($sformatf("illegal_valid[%0d]", d), 64'(vld[d]), 64'd0);
        chk($sformatf("illegal_bus_hold[%0d]", d), 64'(bus[d]), 64'(last_res[d]));
        chk($sformatf("illegal_zero_hold[%0d]", d), 64'(zro[d]), 64'(zf_m));
      end
      return;
    end
    if (hold) begin
      ope = 32'h8900_0000; num_of_ope = 4'hf;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy[%0d] op=%h k=%0d", d, op, k), 64'(bsy[d]), 64'd1);
        chk($sformatf("step[%0d] op=%h k=%0d", d, op, k), 64'(stp[d]), 64'(k));
      end
      registor_in = regs[k];
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("valid[%0d] op=%h k=%0d", d, op, k), 64'(vld[d]), 64'd1);
        chk($sformatf("result[%0d] op=%h k=%0d", d, op, k), 64'(bus[d]), 64'(e[d][k]));
        chk($sformatf("done[%0d] op=%h k=%0d", d, op, k), 64'(dne[d]), 64'(k == n - 1));
        last_res[d] = e[d][k];
      end
      g0[k] = bus[0]; g1[k] = bus[1];
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_end[%0d] op=%h", d, op), 64'(bsy[d]), 64'd0);
      chk($sformatf("zero[%0d] op=%h", d, op), 64'(zro[d]), 64'(zf_m));
    end
  endtask

  typedef struct {
    logic [31:0]      op;
    logic [3:0]       len;
    logic [2:0][31:0] regs;
    bit               sd;
    int               n;
    logic [2:0][31:0] exp;
    bit               zf;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [2:0][31:0] g0, g1, got, regs;
    logic [31:0] op;
    logic [7:0] opc, mr;
    logic [7:0] opc_list [15];

    vecs[0] = '{32'h5500_0000, 4'd1, r3(32'h100, 32'h1234, 0), 1'b0, 2, r3(32'h104, 32'h1234, 0), 1'b0};
    vecs[1] = '{32'hE8EE_FFFF, 4'd5, r3(32'h200, 32'h30, 32'h30), 1'b0, 3, r3(32'h204, 32'h35, 32'h23), 1'b0};
    vecs[2] = '{32'h837D_FC05, 4'd4, r3(32'h80, 32'h5, 0), 1'b0, 2, r3(32'h7C, 32'h0, 0), 1'b1};
    vecs[3] = '{32'h75F0_0000, 4'd2, r3(32'h40, 0, 0), 1'b0, 1, r3(32'h42, 0, 0), 1'b1};
    vecs[4] = '{32'h837D_FC05, 4'd4, r3(32'h80, 32'h6, 0), 1'b0, 2, r3(32'h7C, 32'h1, 0), 1'b0};
    vecs[5] = '{32'h75F0_0000, 4'd2, r3(32'h40, 0, 0), 1'b0, 1, r3(32'h32, 0, 0), 1'b0};
    vecs[6] = '{32'h5300_0000, 4'd1, r3(32'h100, 32'h77, 0), 1'b1, 2, r3(32'hFC, 32'h77, 0), 1'b0};
    vecs[7] = '{32'h83C4_0800, 4'd3, r3(32'hFC, 0, 0), 1'b1, 1, r3(32'h104, 0, 0), 1'b0};
    vecs[8] = '{32'h5D00_0000, 4'd1, r3(32'h10, 32'hFFFF_FFFE, 0), 1'b1, 2, r3(32'h10, 32'h2, 0), 1'b0};
    vecs[9] = '{32'h5D00_0000, 4'd1, r3(32'h10, 32'hFFFF_FFFE, 0), 1'b0, 2, r3(32'h10, 32'hFFFF_FFFA, 0), 1'b0};

    opc_list = '{8'h55, 8'h53, 8'h6a, 8'h5d, 8'hc3, 8'he8, 8'hc9, 8'h89,
                 8'hb8, 8'h8b, 8'h83, 8'h75, 8'heb, 8'h0f, 8'h00};
    last_res[0] = '0; last_res[1] = '0;

    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outputs[%0d]", d),
          64'({stp[d], bsy[d], vld[d], bus[d], zro[d], dne[d], ill[d]}), 64'd0);
    reset = 1'b0;

    // Directed vectors with hand-derived results.
    for (int i = 0; i < 10; i++) begin
      run(vecs[i].op, vecs[i].len, vecs[i].regs, 1'b0, g0, g1);
      got = vecs[i].sd ? g1 : g0;
      for (int k = 0; k < vecs[i].n; k++)
        chk($sformatf("vec%0d_result k=%0d", i, k), 64'(got[k]), 64'(vecs[i].exp[k]));
      chk($sformatf("vec%0d_zero", i), 64'(zro[vecs[i].sd]), 64'(vecs[i].zf));
    end

    // start held high with changing ope while busy must not disturb the call.
    run(32'hE8EE_FFFF, 4'd5, r3(32'h200, 32'h30, 32'h30), 1'b1, g0, g1);
    chk("hold_call_ret_addr", 64'(g0[1]), 64'h35);

    run(32'h0F00_0000, 4'd2, r3(1, 2, 3), 1'b0, g0, g1);
    run(32'h8300_0000, 4'd3, r3(1, 2, 3), 1'b0, g0, g1);

    // Reset after the first step of a call aborts it.
    start = 1'b1; ope = 32'hE8EE_FFFF; num_of_ope = 4'd5; registor_in = 32'h200;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("abort_step0_result", 64'(bus[0]), 64'h204);
    reset = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      chk($sformatf("abort_outputs[%0d]", d),
          64'({stp[d], bsy[d], vld[d], bus[d], zro[d], dne[d], ill[d]}), 64'd0);
    reset = 1'b0;
    zf_m = 1'b0; last_res[0] = '0; last_res[1] = '0;
    run(32'h5500_0000, 4'd1, r3(32'h100, 32'h1234, 0), 1'b0, g0, g1);

    // Randomised instructions against the model.
    for (int i = 0; i < 300; i++) begin
      opc = opc_list[$urandom_range(0, 14)];
      mr = 8'($urandom);
      if (opc == 8'h83) begin
        case ($urandom_range(0, 4))
          0: mr = 8'he8;
          1: mr = 8'hc4;
          2: mr = 8'hec;
          3: mr = 8'h7d;
          default: ;
        endcase
      end
      op = {opc, mr, 16'($urandom)};
      regs = {32'($urandom), 32'($urandom), 32'($urandom)};
      if (opc == 8'h83 && ($urandom_range(0, 1) == 1)) begin
        if (mr == 8'he8) regs[0] = 32'(s8(op[15:8]));
        if (mr == 8'h7d) regs[1] = 32'(s8(op[7:0]));
      end
      run(op, 4'($urandom_range(1, 15)), regs, ($urandom_range(0, 3) == 0), g0, g1);
    end

    @(negedge clock);
    for (int d = 0; d < 2; d++)
      chk($sformatf("idle_no_done[%0d]", d), 64'({dne[d], vld[d], bsy[d]}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
